counter_mod100_down: RTL and testbench

Mod-100 programmable down-counter and timer. It is the counting-down counterpart to the team's mod-100 up counter. It counts from a loaded value (0..99) toward 0 and raises a one-cycle terminal-count pulse on expiry. In one-shot mode it stops in DONE; in auto-reload mode it wraps to the stored reload value (99 by default). It sits in the counters library alongside the mod-N up counters and provides both binary and two-digit BCD outputs for display paths.

---
 rtl/counter_pkg.sv | 32 +++
 rtl/bcd_digit_down.sv | 37 +++
 rtl/counter_mod100_down.sv | 156 +++++++++++++++
 tb/tb_counter_mod100_down.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the counters library:
//     MOD_100, WIDTH_100 : modulus and binary width of the mod-100 counters
//     state_t            : counter state encoding (IDLE, RUN, HOLD, DONE)
//     sat_load()         : clamps a load value into 0..MOD_100-1
//     to_bcd()           : splits a 0..99 binary value into {tens, ones}
package counter_pkg;

  localparam int MOD_100   = 100;
  localparam int WIDTH_100 = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Out-of-range load values clamp to the top legal count rather than wrapping.
  function automatic logic [WIDTH_100-1:0] sat_load(input logic [WIDTH_100-1:0] v);
    logic [WIDTH_100-1:0] lim;
    lim = WIDTH_100'(MOD_100 - 1);
    return (v > lim) ? lim : v;
  endfunction

  // Only used on load values (already saturated), never on the running count;
  // the running digits are kept in step by the digit counters instead.
  function automatic logic [7:0] to_bcd(input logic [WIDTH_100-1:0] v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down
//   One decimal digit of a BCD down-counter.
//   Ports:
//     clk      : rising-edge clock
//     rst      : synchronous active-low reset, digit returns to 0
//     load     : capture load_val (wins over dec)
//     load_val : digit value to load, 0..9
//     dec      : decrement enable
//     digit    : registered digit value
//     borrow   : combinational, high when decrementing from 0 this cycle
//   Parameter WRAP is the value the digit takes after decrementing from 0.
module bcd_digit_down #(
  parameter logic [3:0] WRAP = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       borrow
);

  // Borrow is combinational so the next digit up can decrement on the same edge.
  assign borrow = dec && (digit == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec) begin
      digit <= (digit == 4'd0) ? WRAP : digit - 4'd1;
    end
  end

endmodule

// File: rtl/counter_mod100_down.sv
// counter_mod100_down
//   Mod-100 programmable down-counter / timer with one-shot and auto-reload
//   modes, binary and two-digit BCD outputs.
//   Ports:
//     clk         : rising-edge clock
//     rst         : synchronous active-low reset
//     load        : load load_val into count and reload register (IDLE/DONE only)
//     load_val    : load value, values >= MOD saturate to MOD-1
//     start       : begin counting (IDLE/DONE only)
//     pause       : level, freezes the count while high during a run
//     auto_reload : 1 = wrap to reload value at expiry, 0 = one-shot
//     count       : registered binary count
//     tens, ones  : registered BCD digits of count
//     tc          : one-cycle terminal-count pulse
//     busy        : high in RUN or HOLD
//     done        : high in DONE
module counter_mod100_down
  import counter_pkg::*;
#(
  parameter int MOD   = MOD_100,
  parameter int WIDTH = WIDTH_100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] RELOAD_INIT = WIDTH'(MOD - 1);
  localparam logic [7:0]       RELOAD_BCD  = to_bcd(RELOAD_INIT);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic [3:0]       reload_tens;
  logic [3:0]       reload_ones;

  logic             load_acc;
  logic             run_step;
  logic             at_zero;
  logic [WIDTH-1:0] load_sat;
  logic [7:0]       load_bcd;

  logic             ones_dec;
  logic             ones_borrow;
  logic             tens_borrow;
  logic             dig_load;
  logic [3:0]       dig_tens_val;
  logic [3:0]       dig_ones_val;

  // Shared decode used by both the FSM and the digit chain, so the binary
  // count and the BCD digits always take the same decision on an edge.
  always_comb begin
    load_acc = load && ((state == IDLE) || (state == DONE));
    run_step = (state == RUN) && !pause;
    at_zero  = (count == '0);
    load_sat = sat_load(load_val);
    load_bcd = to_bcd(load_sat);

    // At zero in one-shot mode the digits must hold; in auto-reload mode the
    // decrement is allowed through so the borrow ripples out of the tens digit,
    // and that tens borrow is what triggers the digit reload below.
    ones_dec = run_step && (!at_zero || auto_reload);

    dig_load     = load_acc || tens_borrow;
    dig_tens_val = load_acc ? load_bcd[7:4] : reload_tens;
    dig_ones_val = load_acc ? load_bcd[3:0] : reload_ones;
  end

  bcd_digit_down #(.WRAP(4'd9)) u_ones (
    .clk      (clk),
    .rst      (rst),
    .load     (dig_load),
    .load_val (dig_ones_val),
    .dec      (ones_dec),
    .digit    (ones),
    .borrow   (ones_borrow)
  );

  bcd_digit_down #(.WRAP(4'd9)) u_tens (
    .clk      (clk),
    .rst      (rst),
    .load     (dig_load),
    .load_val (dig_tens_val),
    .dec      (ones_borrow),
    .digit    (tens),
    .borrow   (tens_borrow)
  );

  // Control FSM with the binary count, reload register and registered flags.
  // tc defaults low every edge so it can only ever be a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      reload      <= RELOAD_INIT;
      reload_tens <= RELOAD_BCD[7:4];
      reload_ones <= RELOAD_BCD[3:0];
      tc          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load_acc) begin
            count       <= load_sat;
            reload      <= load_sat;
            reload_tens <= load_bcd[7:4];
            reload_ones <= load_bcd[3:0];
            state       <= IDLE;
            done        <= 1'b0;
            busy        <= 1'b0;
          end else if (start) begin
            state <= RUN;
            done  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (pause) begin
            state <= HOLD;
          end else if (!at_zero) begin
            count <= count - WIDTH'(1);
          end else if (auto_reload) begin
            count <= reload;
            tc    <= 1'b1;
          end else begin
            tc    <= 1'b1;
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        HOLD: begin
          if (!pause) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_mod100_down.sv
// tb_counter_mod100_down
//   Directed bench for counter_mod100_down: a table of single-edge vectors
//   followed by hand-written multi-cycle sequences (reset, free run, pause,
//   reset mid-run, zero reload value).
module tb_counter_mod100_down;

  logic       clk;
  logic       rst;
  logic       load;
  logic [6:0] load_val;
  logic       start;
  logic       pause;
  logic       auto_reload;
  logic [6:0] count;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       tc;
  logic       busy;
  logic       done;

  int total;
  int bad;

  typedef struct {
    logic       r;
    logic       l;
    logic [6:0] lv;
    logic       s;
    logic       p;
    logic       ar;
    int         exp_count;
    logic       exp_tc;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs[20];

  counter_mod100_down dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .pause       (pause),
    .auto_reload (auto_reload),
    .count       (count),
    .tens        (tens),
    .ones        (ones),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, let one rising edge happen, then return at the falling edge
  // so outputs are sampled away from the active edge.
  task automatic applyStimulus(input logic r, input logic l, input logic [6:0] lv,
                               input logic s, input logic p, input logic ar);
    rst         = r;
    load        = l;
    load_val    = lv;
    start       = s;
    pause       = p;
    auto_reload = ar;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int exp_count, input logic exp_tc,
                             input logic exp_busy, input logic exp_done);
    logic [3:0] et;
    logic [3:0] eo;
    et = 4'(exp_count / 10);
    eo = 4'(exp_count % 10);
    total++;
    if (count !== 7'(exp_count) || tens !== et || ones !== eo ||
        tc !== exp_tc || busy !== exp_busy || done !== exp_done) begin
      bad++;
      $display("[TB] FAIL %s: got count=%0d tens=%0d ones=%0d tc=%b busy=%b done=%b, want count=%0d tens=%0d ones=%0d tc=%b busy=%b done=%b",
               name, count, tens, ones, tc, busy, done,
               exp_count, et, eo, exp_tc, exp_busy, exp_done);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset", 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_idle", 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int m;
    int tcs;
    logic etc;

    total       = 0;
    bad         = 0;
    rst         = 1'b0;
    load        = 1'b0;
    load_val    = 7'd0;
    start       = 1'b0;
    pause       = 1'b0;
    auto_reload = 1'b0;

    //             r  l  lv      s  p  ar  count tc busy done
    vecs[0]  = '{1'b1, 1'b1, 7'd5,   1'b0, 1'b0, 1'b0, 5,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 7'd0,   1'b1, 1'b0, 1'b0, 5,  1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 0,  1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 7'd120, 1'b0, 1'b0, 1'b0, 99, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 7'd0,   1'b1, 1'b0, 1'b0, 99, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 98, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 7'd30,  1'b0, 1'b0, 1'b0, 97, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 7'd0,   1'b1, 1'b0, 1'b0, 96, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 7'd3,   1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 7'd0,   1'b1, 1'b1, 1'b0, 3,  1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b1, 1'b0, 3,  1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0};

    doReset();

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].r, vecs[i].l, vecs[i].lv, vecs[i].s, vecs[i].p, vecs[i].ar);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_tc,
                  vecs[i].exp_busy, vecs[i].exp_done);
    end

    // Free run from reset with the default reload of 99.
    doReset();
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("free_start", 0, 1'b0, 1'b1, 1'b0);
    m   = 0;
    tcs = 0;
    for (int i = 0; i < 250; i++) begin
      applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
      if (m == 0) begin
        m   = 99;
        etc = 1'b1;
        tcs++;
      end else begin
        m   = m - 1;
        etc = 1'b0;
      end
      checkOutput($sformatf("free%0d", i), m, etc, 1'b1, 1'b0);
    end
    total++;
    if (tcs != 3) begin
      bad++;
      $display("[TB] FAIL free_tc_count: got %0d, want 3", tcs);
    end

    // Pause at 15 for four edges, then resume.
    doReset();
    applyStimulus(1'b1, 1'b1, 7'd20, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("pause_pre", 15, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("pause%0d", i), 15, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("pause_release", 15, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("pause_resume", 14, 1'b0, 1'b1, 1'b0);

    // Reset mid-run at 57, then confirm the reload register went back to 99.
    doReset();
    applyStimulus(1'b1, 1'b1, 7'd99, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 42; i++) applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrun_57", 57, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrun_reset", 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("midrun_restart", 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("midrun_reload99", 99, 1'b1, 1'b1, 1'b0);

    // Reload value 0 in auto-reload mode: tc on every RUN cycle.
    doReset();
    applyStimulus(1'b1, 1'b1, 7'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("zero_load", 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("zero_start", 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("zero_tc%0d", i), 0, 1'b1, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
